// File: rtl/regfile_mp_pkg.sv
// Shared widths and port-count limits for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned DEF_AWIDTH = 5;
  localparam int unsigned MAX_NUM_RD = 4;
  localparam int unsigned MAX_NUM_WR = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, plus busy lookup per read port.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic [NUM_WR-1:0]        wr_act,
  input  logic [NUM_WR*AWIDTH-1:0] wr_addr,
  input  logic [NUM_RD*AWIDTH-1:0] rd_addr,
  input  logic                     set_en,
  input  logic [AWIDTH-1:0]        set_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        busy
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nx;

  // Completing writes clear, issue sets (younger producer wins), flush clears all.
  always_comb begin
    pending_nx = pending;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_act[k]) pending_nx[wr_addr[k*AWIDTH +: AWIDTH]] = 1'b0;
    end
    if (set_en && (set_addr != '0)) pending_nx[set_addr] = 1'b1;
    if (flush) pending_nx = '0;
  end

  // Pending-bit register.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) pending <= '0;
    else        pending <= pending_nx;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_busy
    logic [AWIDTH-1:0] addr;
    logic              hit;

    assign addr = rd_addr[j*AWIDTH +: AWIDTH];

    // A same-cycle matching write resolves the hazard when bypass is on.
    always_comb begin
      hit = 1'b0;
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_act[k] && (wr_addr[k*AWIDTH +: AWIDTH] == addr)) hit = 1'b1;
        end
      end
    end

    assign busy[j] = pending[addr] && !hit && (addr != '0);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero r0, optional write bypass and RAW scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DWIDTH      = DEF_DWIDTH,
  parameter int unsigned AWIDTH      = DEF_AWIDTH,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned NUM_WR      = 1,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          RESET_INDEX = 1'b1
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic [NUM_WR-1:0]        r_wr_en,
  input  logic [NUM_WR*AWIDTH-1:0] r_wr_addr,
  input  logic [NUM_WR*DWIDTH-1:0] r_wr_data,
  input  logic [NUM_RD*AWIDTH-1:0] r_rd_addr,
  output logic [NUM_RD*DWIDTH-1:0] r_rd_data,
  output logic [NUM_RD-1:0]        r_rd_busy,
  input  logic                     r_sb_set_en,
  input  logic [AWIDTH-1:0]        r_sb_set_addr,
  input  logic                     r_sb_flush
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] wr_act;

  // Effective write: enabled, nonzero target, and not masked by an asserted reset.
  always_comb begin
    wr_act = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_act[k] = r_rst && r_wr_en[k] && (r_wr_addr[k*AWIDTH +: AWIDTH] != '0);
    end
  end

  // Storage; ascending port order makes the highest-index port win a collision.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_INDEX ? DWIDTH'(i) : '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_act[k]) mem[r_wr_addr[k*AWIDTH +: AWIDTH]] <= r_wr_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;

    assign addr = r_rd_addr[j*AWIDTH +: AWIDTH];

    // Stored value, overridden by the winning same-cycle write when bypass is on.
    always_comb begin
      data = mem[addr];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_act[k] && (r_wr_addr[k*AWIDTH +: AWIDTH] == addr)) begin
            data = r_wr_data[k*DWIDTH +: DWIDTH];
          end
        end
      end
    end

    assign r_rd_data[j*DWIDTH +: DWIDTH] = data;
  end

  regfile_scoreboard #(
    .AWIDTH (AWIDTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS)
  ) u_sb (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .wr_act   (wr_act),
    .wr_addr  (r_wr_addr),
    .rd_addr  (r_rd_addr),
    .set_en   (r_sb_set_en),
    .set_addr (r_sb_set_addr),
    .flush    (r_sb_flush),
    .busy     (r_rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two instances (bypass on / off) share stimulus; a monitor pops expectations.
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             r_rst;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic             sb_flush;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    busy_b, busy_n;

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1), .RESET_INDEX(1'b1)) dut_b (
    .r_clk(clk), .r_rst(r_rst), .r_wr_en(wr_en), .r_wr_addr(wr_addr), .r_wr_data(wr_data),
    .r_rd_addr(rd_addr), .r_rd_data(rd_data_b), .r_rd_busy(busy_b),
    .r_sb_set_en(sb_set_en), .r_sb_set_addr(sb_set_addr), .r_sb_flush(sb_flush));

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0), .RESET_INDEX(1'b1)) dut_n (
    .r_clk(clk), .r_rst(r_rst), .r_wr_en(wr_en), .r_wr_addr(wr_addr), .r_wr_data(wr_data),
    .r_rd_addr(rd_addr), .r_rd_data(rd_data_n), .r_rd_busy(busy_n),
    .r_sb_set_en(sb_set_en), .r_sb_set_addr(sb_set_addr), .r_sb_flush(sb_flush));

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_pend [DEPTH];

  // Reference register file: index-valued reset, nothing pending.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = 32'(i);
      m_pend[i] = 1'b0;
    end
  endtask

  // Reference state change at a rising edge, from the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k] && wr_addr[k*AW +: AW] != 5'd0) m_mem[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
    end
    if (sb_flush) begin
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k]) m_pend[wr_addr[k*AW +: AW]] = 1'b0;
      end
      if (sb_set_en && sb_set_addr != 5'd0) m_pend[sb_set_addr] = 1'b1;
    end
  endtask

  // Expected read-port view for both instances under the current inputs.
  task automatic push_expected();
    for (int inst = 0; inst < 2; inst++) begin
      for (int j = 0; j < NR; j++) begin
        exp_t        e;
        logic [4:0]  a;
        bit          found;
        logic [31:0] wd;
        a = rd_addr[j*AW +: AW];
        found = 1'b0;
        wd = '0;
        for (int k = 0; k < NW; k++) begin
          if (wr_en[k] && wr_addr[k*AW +: AW] == a) begin
            found = 1'b1;
            wd = wr_data[k*DW +: DW];
          end
        end
        e.inst = inst;
        e.port = j;
        e.cyc  = cyc;
        if (!r_rst) begin
          e.data = 32'(a);
          e.busy = 1'b0;
        end else if (a == 5'd0) begin
          e.data = '0;
          e.busy = 1'b0;
        end else if (inst == 0 && found) begin
          e.data = wd;
          e.busy = 1'b0;
        end else begin
          e.data = m_mem[a];
          e.busy = m_pend[a];
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1, input logic se,
                       input logic [4:0] sa, input logic fl, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic rst_v);
    @(posedge clk);
    #1;
    r_rst = rst_v;
    wr_en = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    sb_set_en = se;
    sb_set_addr = sa;
    sb_flush = fl;
    rd_addr = {ra1, ra0};
    cyc++;
    if (!rst_v) model_reset();
    push_expected();
    if (rst_v) model_edge();
  endtask

  // Write and set in flight, then reset drops between edges.
  task automatic drive_reset_midcycle(input logic [4:0] wa, input logic [31:0] wd,
                                      input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    r_rst = 1'b1;
    wr_en = 2'b01;
    wr_addr = {5'd0, wa};
    wr_data = {32'd0, wd};
    sb_set_en = 1'b1;
    sb_set_addr = wa;
    sb_flush = 1'b0;
    rd_addr = {ra1, ra0};
    cyc++;
    #2;
    r_rst = 1'b0;
    model_reset();
    push_expected();
  endtask

  // Monitor: the read ports are always presenting; compare everything queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      e = q.pop_front();
      ad = (e.inst == 0) ? rd_data_b[e.port*DW +: DW] : rd_data_n[e.port*DW +: DW];
      ab = (e.inst == 0) ? busy_b[e.port] : busy_n[e.port];
      checks++;
      if (ad !== e.data) begin
        failures++;
        $display("FAIL rd_data inst=%0d port=%0d cyc=%0d got=%h exp=%h", e.inst, e.port, e.cyc, ad, e.data);
      end
      checks++;
      if (ab !== e.busy) begin
        failures++;
        $display("FAIL rd_busy inst=%0d port=%0d cyc=%0d got=%b exp=%b", e.inst, e.port, e.cyc, ab, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    r_rst = 1'b0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    sb_set_en = 1'b0;
    sb_set_addr = '0;
    sb_flush = 1'b0;
    model_reset();

    // Reset contents, r0 write discarded.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd31, 1'b0);
    drive(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31, 1'b1);
    // Same-cycle bypass vs stored value.
    drive(2'b01, 5'd7, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd6, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 1'b1);
    // Write-port collision: port 1 wins.
    drive(2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB, 1'b0, 5'd0, 1'b0, 5'd5, 5'd4, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b1);
    // Pending r9 for three cycles, then completing write.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 1'b1);
    drive(2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 1'b1);
    // Set and write r4 together: set wins; then flush.
    drive(2'b10, 5'd0, 32'd0, 5'd4, 32'h77, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4, 1'b1);
    // Set on r0 is ignored.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1);
    // Mid-cycle reset drops the in-flight write and set.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd7, 1'b1);
    drive_reset_midcycle(5'd7, 32'h999, 5'd7, 5'd12);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd12, 1'b1);

    // Randomised traffic biased toward a small address pool to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  wa0, wa1, ra0, ra1, sa;
      logic [1:0]  we;
      logic        se, fl;
      logic [31:0] d0, d1;
      wa0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 7));
      we  = 2'($urandom_range(0, 3));
      d0  = $urandom();
      d1  = $urandom();
      se  = ($urandom_range(0, 2) == 0);
      sa  = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 15) == 0);
      ra0 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 79) == 0) drive_reset_midcycle(wa0, d0, ra0, ra1);
      else drive(we, wa0, d0, wa1, d1, se, sa, fl, ra0, ra1, 1'b1);
    end

    for (int w = 0; w < 4 && q.size() > 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    if (checks < 12) begin
      failures++;
      $display("FAIL check_count got=%0d exp>=12", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
